pl_reg_elastic: RTL and testbench
=================================

// Module: pl_reg_elastic
// PURPOSE
//  Parametrised elastic pipeline stage register: the successor to the fixed-field stage registers.
//  Payload is split into a CTRL field (zeroed on flush, so a bubble becomes a NOP) and a DATA field.
//  A valid/ready handshake on both sides replaces the separate enable/clear pair.
//  Instantiated between any two core stages (F/D, D/E, E/M, M/W); the hazard unit drives stall_i and flush_i.
// PARAMETERS
//  DATA_WIDTH  64  width of data payload (operands, PC, immediates, concatenated)
//  CTRL_WIDTH  16  width of control payload (reg_write, res_src, alu_control, ...); must be >= 1
//  CNT_WIDTH   16  width of the back-pressure cycle counter
// PORTS
//  clk          in   1           clock; all state updates on posedge
//  rst          in   1           synchronous, active-high reset
//  flush_i      in   1           kill stage contents (branch/jump redirect)
//  stall_i      in   1           hold: block acceptance of new input
//  valid_i      in   1           upstream payload valid
//  ready_o      out  1           stage can accept this cycle
//  ctrl_i       in   CTRL_WIDTH  upstream control payload
//  data_i       in   DATA_WIDTH  upstream data payload
//  valid_o      out  1           downstream payload valid
//  ready_i      in   1           downstream accepts
//  ctrl_o       out  CTRL_WIDTH  registered control payload
//  data_o       out  DATA_WIDTH  registered data payload
//  bp_cnt_o     out  CNT_WIDTH   cycles spent with valid_o=1 and ready_i=0
// BEHAVIOUR
//  Reset (rst=1 at posedge): valid_o=0, ctrl_o=0, data_o=0, bp_cnt_o=0, skid entry empty; ready_o=1 the following cycle (unless stall_i).
//  in_fire = valid_i & ready_o; out_fire = valid_o & ready_i. Latency in->out: 1 cycle.
//  ready_o never depends combinationally on valid_i. stall_i forces ready_o=0; output side is unaffected.
//  Priority per cycle: rst > flush_i > normal update.
//  flush_i: valid_o<=0, ctrl_o<=0, skid invalidated; data_o holds; the input offered that cycle is dropped.
//  Normal: if in_fire, load ctrl/data, valid_o<=1; else if out_fire, valid_o<=0, ctrl_o<=0.
//  Simultaneous in_fire and out_fire: new payload replaces the old one, valid_o stays 1, no bubble.
//  Payload is stable while valid_o=1 and ready_i=0, except under flush_i.
//  bp_cnt_o: +1 each cycle with valid_o & ~ready_i; saturates at all-ones; cleared by rst only, not by flush_i.
// CONFIGURATION
//  PL_REG_SKID_EN not defined: single entry; ready_o = ~stall_i & (ready_i | ~valid_o), which is combinational in ready_i.
//  PL_REG_SKID_EN defined: 2-entry skid buffer; ready_o = ~stall_i & (state!=SKID), a registered function of state (no ready_i path).
//   States: EMPTY, FULL, SKID (main + skid valid).
//    EMPTY: in_fire -> FULL.
//    FULL: in_fire & ~out_fire -> SKID (input captured in skid); in_fire & out_fire -> FULL (main<=input); out_fire only -> EMPTY.
//    SKID: out_fire -> FULL (main<=skid); no in_fire possible.
//   flush_i returns any state to EMPTY. Ordering is strictly FIFO; no payload is lost or duplicated.
// STRUCTURE
//  Shared package pl_pkg: state localparams (PL_ST_EMPTY/FULL/SKID, 2-bit) and the all-zero NOP control constant.
//  One sub-module: pl_sat_counter (CNT_WIDTH, inc, rst, saturating) implementing bp_cnt_o.
// TESTING (run every scenario with PL_REG_SKID_EN both defined and undefined)
//  Reset: rst=1 for 2 cycles with valid_i=1 -> valid_o=0, ctrl_o=0, data_o=0, bp_cnt_o=0; ready_o=1 after release.
//  Streaming: valid_i=1, ready_i=1, data 1..8 -> data_o 1..8 one cycle later, valid_o continuous, no bubbles.
//  Back-pressure: ready_i=0 for 5 cycles with data 0xA5 held -> data_o stable at 0xA5; bp_cnt_o=5.
//   Skid build only: exactly one extra item accepted, then ready_o=0; order preserved on release.
//  Flush: flush_i=1 and valid_i=1 in same cycle, FULL/SKID -> next cycle valid_o=0, ctrl_o=0, skid empty, input dropped.
//  Stall: stall_i=1 with valid_i=1, ready_i=1 -> ready_o=0; held item drains; no new item is accepted.
//  Saturation: CNT_WIDTH=4, ready_i=0 for 20 cycles -> bp_cnt_o sticks at 0xF.

Source files
------------

// File: rtl/pl_pkg.sv
// Shared definitions for the elastic pipeline stage registers: stage state
// encoding and the all-zero NOP control word used for bubbles.
package pl_pkg;

    typedef enum logic [1:0] {
        PL_ST_EMPTY = 2'd0,
        PL_ST_FULL  = 2'd1,
        PL_ST_SKID  = 2'd2
    } pl_state_e;

    // Widest control payload supported; stages slice their own width from it.
    localparam int unsigned PL_CTRL_MAX_W = 256;
    localparam logic [PL_CTRL_MAX_W-1:0] PL_CTRL_NOP = '0;

endpackage

// File: rtl/pl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module pl_sat_counter
    import pl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pl_reg_elastic.sv
// Elastic pipeline stage register with valid/ready handshake, flush-to-NOP and
// back-pressure counter. Define PL_REG_SKID_EN for the 2-entry skid variant.
module pl_reg_elastic
    import pl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  stall_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [CTRL_WIDTH-1:0] ctrl_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [CTRL_WIDTH-1:0] ctrl_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CNT_WIDTH-1:0]  bp_cnt_o
);

    localparam logic [CTRL_WIDTH-1:0] CTRL_NOP = PL_CTRL_NOP[CTRL_WIDTH-1:0];

    pl_state_e             state_q, state_d;
    logic [CTRL_WIDTH-1:0] ctrl_q,  ctrl_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
`ifdef PL_REG_SKID_EN
    logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
`endif

    logic in_fire;
    logic out_fire;

    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_o & ready_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PL_ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; SKID is only reachable in the skid build
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PL_ST_EMPTY: if (in_fire) state_d = PL_ST_FULL;
            PL_ST_FULL: begin
`ifdef PL_REG_SKID_EN
                if (in_fire && !out_fire) state_d = PL_ST_SKID;
                else if (!in_fire && out_fire) state_d = PL_ST_EMPTY;
`else
                if (!in_fire && out_fire) state_d = PL_ST_EMPTY;
`endif
            end
            PL_ST_SKID: if (out_fire) state_d = PL_ST_FULL;
            default: state_d = PL_ST_EMPTY;
        endcase
        if (flush_i) state_d = PL_ST_EMPTY;
    end

    // Output logic
    always_comb begin
        valid_o = (state_q != PL_ST_EMPTY);
`ifdef PL_REG_SKID_EN
        ready_o = ~stall_i & (state_q != PL_ST_SKID);
`else
        ready_o = ~stall_i & (ready_i | (state_q == PL_ST_EMPTY));
`endif
    end

    // Payload path: flush zeroes control but leaves data as-is
    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
`ifdef PL_REG_SKID_EN
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
`endif
        if (flush_i) begin
            ctrl_d = CTRL_NOP;
        end else begin
            unique case (state_q)
                PL_ST_EMPTY: begin
                    if (in_fire) begin
                        ctrl_d = ctrl_i;
                        data_d = data_i;
                    end
                end
                PL_ST_FULL: begin
                    if (in_fire && out_fire) begin
                        ctrl_d = ctrl_i;
                        data_d = data_i;
`ifdef PL_REG_SKID_EN
                    end else if (in_fire) begin
                        skid_ctrl_d = ctrl_i;
                        skid_data_d = data_i;
`endif
                    end else if (out_fire) begin
                        ctrl_d = CTRL_NOP;
                    end
                end
                PL_ST_SKID: begin
`ifdef PL_REG_SKID_EN
                    if (out_fire) begin
                        ctrl_d = skid_ctrl_q;
                        data_d = skid_data_q;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
            data_q <= '0;
`ifdef PL_REG_SKID_EN
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
`endif
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
`ifdef PL_REG_SKID_EN
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
`endif
        end
    end

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

    pl_sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_bp_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (valid_o & ~ready_i),
        .cnt_o (bp_cnt_o)
    );

endmodule

// File: tb/tb_pl_reg_elastic.sv
// Directed bench for pl_reg_elastic; expectations adapt to PL_REG_SKID_EN.
module tb_pl_reg_elastic;

`ifdef PL_REG_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush_i, stall_i, valid_i, ready_i;
    logic        ready_o, valid_o;
    logic [15:0] ctrl_i, ctrl_o, bp_cnt_o;
    logic [63:0] data_i, data_o;

    logic        s_rst, s_flush_i, s_stall_i, s_valid_i, s_ready_i;
    logic        s_ready_o, s_valid_o;
    logic [3:0]  s_ctrl_i, s_ctrl_o, s_bp_cnt_o;
    logic [7:0]  s_data_i, s_data_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    pl_reg_elastic #(
        .DATA_WIDTH(64), .CTRL_WIDTH(16), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
        .valid_i(valid_i), .ready_o(ready_o), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(valid_o), .ready_i(ready_i), .ctrl_o(ctrl_o), .data_o(data_o),
        .bp_cnt_o(bp_cnt_o)
    );

    pl_reg_elastic #(
        .DATA_WIDTH(8), .CTRL_WIDTH(4), .CNT_WIDTH(4)
    ) dut_sat (
        .clk(clk), .rst(s_rst), .flush_i(s_flush_i), .stall_i(s_stall_i),
        .valid_i(s_valid_i), .ready_o(s_ready_o), .ctrl_i(s_ctrl_i), .data_i(s_data_i),
        .valid_o(s_valid_o), .ready_i(s_ready_i), .ctrl_o(s_ctrl_o), .data_o(s_data_o),
        .bp_cnt_o(s_bp_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
        valid_i = 1'b1; ready_i = 1'b1; ctrl_i = 16'h0003; data_i = 64'h55;
        s_rst = 1'b1; s_flush_i = 1'b0; s_stall_i = 1'b0;
        s_valid_i = 1'b0; s_ready_i = 1'b0; s_ctrl_i = 4'h0; s_data_i = 8'h00;

        tick(); tick();
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_ctrl", 64'(ctrl_o), 64'd0);
        check("rst_data", data_o, 64'd0);
        check("rst_bp", 64'(bp_cnt_o), 64'd0);
        rst = 1'b0; valid_i = 1'b0;
        #1;
        check("rst_ready", 64'(ready_o), 64'd1);

        for (int i = 1; i <= 8; i++) begin
            valid_i = 1'b1; data_i = 64'(i); ctrl_i = 16'(16'h0100 + i);
            tick();
            check("stream_valid", 64'(valid_o), 64'd1);
            check("stream_data", data_o, 64'(i));
            check("stream_ctrl", 64'(ctrl_o), 64'(16'h0100 + i));
        end
        valid_i = 1'b0;
        tick();
        check("drain_valid", 64'(valid_o), 64'd0);
        check("drain_ctrl", 64'(ctrl_o), 64'd0);

        valid_i = 1'b1; ready_i = 1'b0; data_i = 64'hA5; ctrl_i = 16'h005A;
        tick();
        check("bp_load", data_o, 64'hA5);
        data_i = 64'hB6; ctrl_i = 16'h006B;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_data", data_o, 64'hA5);
            check("bp_hold_ctrl", 64'(ctrl_o), 64'h5A);
        end
        check("bp_cnt5", 64'(bp_cnt_o), 64'd5);
        check("bp_ready_low", 64'(ready_o), 64'd0);
        ready_i = 1'b1;
        valid_i = SKID ? 1'b0 : 1'b1;
        tick();
        check("bp_next_valid", 64'(valid_o), 64'd1);
        check("bp_next_data", data_o, 64'hB6);
        valid_i = 1'b0;
        tick();
        check("bp_empty", 64'(valid_o), 64'd0);
        check("bp_cnt_keep", 64'(bp_cnt_o), 64'd5);

        valid_i = 1'b1; ready_i = 1'b0; data_i = 64'hC3; ctrl_i = 16'h00C3;
        tick();
        data_i = 64'hD4; ctrl_i = 16'h00D4;
        tick();
        flush_i = 1'b1; data_i = 64'hE7; ctrl_i = 16'h0077;
        tick();
        check("flush_valid", 64'(valid_o), 64'd0);
        check("flush_ctrl", 64'(ctrl_o), 64'd0);
        check("flush_data_hold", data_o, 64'hC3);
        check("flush_bp_kept", 64'(bp_cnt_o), 64'd7);
        flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        tick();
        check("flush_no_skid", 64'(valid_o), 64'd0);
        check("flush_ready", 64'(ready_o), 64'd1);

        valid_i = 1'b1; data_i = 64'hF1; ctrl_i = 16'h00F1;
        tick();
        check("stall_pre", data_o, 64'hF1);
        stall_i = 1'b1; data_i = 64'hF2; ctrl_i = 16'h00F2;
        #1;
        check("stall_ready", 64'(ready_o), 64'd0);
        tick();
        check("stall_drain", 64'(valid_o), 64'd0);
        stall_i = 1'b0; valid_i = 1'b0;

        s_rst = 1'b0; s_valid_i = 1'b1; s_data_i = 8'h3C; s_ctrl_i = 4'h9;
        tick();
        s_valid_i = 1'b0;
        check("sat_load", 64'(s_data_o), 64'h3C);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_cnt14", 64'(s_bp_cnt_o), 64'hE);
            if (i == 15) check("sat_cnt15", 64'(s_bp_cnt_o), 64'hF);
        end
        check("sat_cnt20", 64'(s_bp_cnt_o), 64'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
